// File: rtl/clic_irq_scheduler.sv
// clic_irq_scheduler
//   Picks the highest-priority eligible interrupt source and offers it to the
//   hart through a valid/ready handshake. A request is withdrawn (KILL) when
//   its source stops being eligible or a strictly higher key appears before
//   it is accepted.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ip_i/ie_i/le_i/shv_i  per-source pending, enable, edge, hw-vectored flags
//   intv_i, vsid_i        per-source virtualized flag and VS context id
//   vsprio_i              per-context VS priority
//   intctl_i, thresh_i    per-source level, global level threshold
//   irq_valid_o/ready_i   request handshake; id/level/shv are registered
//   edge_ack_o            one-hot pending-clear pulse for edge sources
//
// Build option
//   CLIC_VSPRIO_EN        prefixes the arbitration key with the VS priority
module clic_irq_scheduler #(
  parameter int unsigned N_SOURCE    = 32,
  parameter int unsigned INTCTLBITS  = 8,
  parameter int unsigned MAX_VSCTXTS = 64,
  parameter int unsigned VsidWidth   = 6,
  parameter int unsigned VsprioWidth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_SOURCE-1:0]          ip_i,
  input  logic [N_SOURCE-1:0]          ie_i,
  input  logic [N_SOURCE-1:0]          le_i,
  input  logic [N_SOURCE-1:0]          shv_i,
  input  logic [N_SOURCE-1:0]          intv_i,
  input  logic [7:0]                   intctl_i [N_SOURCE],
  input  logic [VsidWidth-1:0]         vsid_i   [N_SOURCE],
  input  logic [VsprioWidth-1:0]       vsprio_i [MAX_VSCTXTS],
  input  logic [7:0]                   thresh_i,
  output logic                         irq_valid_o,
  input  logic                         irq_ready_i,
  output logic [$clog2(N_SOURCE)-1:0]  irq_id_o,
  output logic [7:0]                   irq_level_o,
  output logic                         irq_shv_o,
  output logic [N_SOURCE-1:0]          edge_ack_o
);

  localparam int unsigned IdWidth = $clog2(N_SOURCE);
`ifdef CLIC_VSPRIO_EN
  localparam int unsigned KeyWidth = VsprioWidth + 8;
`else
  localparam int unsigned KeyWidth = 8;
`endif
  // Unimplemented low intctl bits read as ones.
  localparam logic [7:0] LvlMask = 8'((1 << (8 - INTCTLBITS)) - 1);

  typedef enum logic [2:0] {IDLE, ARB, REQ, ACK, KILL} state_t;

  state_t               state, state_n;
  logic [7:0]           lvl  [N_SOURCE];
  logic [KeyWidth-1:0]  key  [N_SOURCE];
  logic [N_SOURCE-1:0]  elig;

  logic                 any_elig;
  logic [IdWidth-1:0]   win_id;
  logic [KeyWidth-1:0]  win_key;
  logic [7:0]           win_lvl;
  logic                 win_shv;

  logic [IdWidth-1:0]   reg_id;
  logic [KeyWidth-1:0]  reg_key;
  logic [7:0]           reg_lvl;
  logic                 reg_shv;
  logic                 kill;

  always_comb begin
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      lvl[i]  = intctl_i[i] | LvlMask;
      elig[i] = ip_i[i] & ie_i[i] & (lvl[i] > thresh_i);
`ifdef CLIC_VSPRIO_EN
      if (!intv_i[i])
        key[i] = {{VsprioWidth{1'b1}}, lvl[i]};
      else if (32'(vsid_i[i]) < MAX_VSCTXTS)
        key[i] = {vsprio_i[vsid_i[i]], lvl[i]};
      else
        key[i] = {{VsprioWidth{1'b0}}, lvl[i]};
`else
      key[i] = lvl[i];
`endif
    end
  end

`ifndef CLIC_VSPRIO_EN
  // Virtualization inputs have no effect in this build.
  logic unused_vs;
  always_comb begin
    unused_vs = ^intv_i;
    for (int unsigned i = 0; i < N_SOURCE; i++)
      unused_vs = unused_vs ^ (^vsid_i[i]);
    for (int unsigned j = 0; j < MAX_VSCTXTS; j++)
      unused_vs = unused_vs ^ (^vsprio_i[j]);
  end
`endif

  // Ascending scan with >= so the higher index wins on equal keys.
  always_comb begin
    any_elig = 1'b0;
    win_id   = '0;
    win_key  = '0;
    win_lvl  = '0;
    win_shv  = 1'b0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      if (elig[i] && (!any_elig || key[i] >= win_key)) begin
        any_elig = 1'b1;
        win_id   = IdWidth'(i);
        win_key  = key[i];
        win_lvl  = lvl[i];
        win_shv  = shv_i[i];
      end
    end
  end

  assign kill = !elig[reg_id] || (any_elig && (win_key > reg_key));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      reg_id  <= '0;
      reg_key <= '0;
      reg_lvl <= '0;
      reg_shv <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ARB && any_elig) begin
        reg_id  <= win_id;
        reg_key <= win_key;
        reg_lvl <= win_lvl;
        reg_shv <= win_shv;
      end
    end
  end

  always_comb begin
    state_n    = state;
    edge_ack_o = '0;
    case (state)
      IDLE: if (any_elig) state_n = ARB;
      ARB:  state_n = any_elig ? REQ : IDLE;
      REQ: begin
        // Accepting the request beats withdrawing it.
        if (irq_ready_i)  state_n = ACK;
        else if (kill)    state_n = KILL;
      end
      ACK: begin
        if (le_i[reg_id]) edge_ack_o[reg_id] = 1'b1;
        state_n = IDLE;
      end
      KILL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign irq_valid_o = (state == REQ);
  assign irq_id_o    = reg_id;
  assign irq_level_o = reg_lvl;
  assign irq_shv_o   = reg_shv;

endmodule
